// File: rtl/snpu_rnd_pkg.sv
// Shared definitions for the random-cell harvesting controller:
// FSM encoding, debug view, default parameters and the byte-fold helper.
package snpu_rnd_pkg;

  localparam int N_CELLS_DEF     = 16;
  localparam int RELEASE_CYC_DEF = 4;
  localparam int SETTLE_CYC_DEF  = 3;
  localparam int REP_LIMIT_DEF   = 4;

  // Widest cell bank the fold helper handles; narrower words are zero-extended.
  localparam int FOLD_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CHECK   = 3'd4,
    ST_HOLD    = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  // Debug view of the controller for checkers and benches.
  typedef struct packed {
    state_t     state;
    logic [7:0] rep_cnt;
    logic       prev_valid;
  } dbg_t;

  // XOR of all bytes of the word; zero padding bytes do not change the result.
  function automatic logic [7:0] fold_bytes(input logic [FOLD_MAX_W-1:0] w);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / 8; i++) begin
      acc ^= w[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/rnd_sync2.sv
// N-bit two-flop synchroniser for the asynchronous latch outputs.
module rnd_sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rnd_harvest_ctrl.sv
// Harvest sequencer for the NAND-latch random cell bank: releases and
// freezes the cells, captures the synchronised bits, runs a repetition
// health test and serves the folded byte to one consumer.
//
// Handshake: a byte transfers on a clock edge where out_valid and out_ready
// are both 1. While out_valid=1 and no transfer has happened, out_data is
// held stable and out_valid stays high; out_ready may toggle freely.
module rnd_harvest_ctrl
  import snpu_rnd_pkg::*;
#(
  parameter int N_CELLS     = N_CELLS_DEF,
  parameter int RELEASE_CYC = RELEASE_CYC_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_CELLS-1:0] rnd_bits,
  output logic               gen_freeze,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               health_fail,
  input  logic               fail_clr,
  output dbg_t               dbg
);

  localparam int CNT_MAX = (RELEASE_CYC > SETTLE_CYC) ? RELEASE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int REP_W   = $clog2(REP_LIMIT);

  generate
    if ((N_CELLS % 8 != 0) || (N_CELLS > FOLD_MAX_W) || (N_CELLS < 8) ||
        (SETTLE_CYC < 3) || (RELEASE_CYC < 1) || (REP_LIMIT < 2)) begin : g_bad_params
      $error("rnd_harvest_ctrl: illegal parameter set");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_CELLS-1:0] rnd_sync;
  logic [N_CELLS-1:0] word;
  logic [N_CELLS-1:0] prev_word;
  logic               prev_valid;
  logic [REP_W-1:0]   rep_cnt;
  logic [REP_W-1:0]   rep_next;
  logic               rep_fail;
  logic [7:0]         fold;

  rnd_sync2 #(.W(N_CELLS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rnd_bits),
    .q     (rnd_sync)
  );

  // Repetition test on the freshly captured word against the previous capture.
  always_comb begin
    rep_next = '0;
    rep_fail = 1'b0;
    fold     = fold_bytes(FOLD_MAX_W'(word));
    if (prev_valid && (word == prev_word)) begin
      rep_next = rep_cnt + 1'b1;
    end
    if (rep_next == REP_W'(REP_LIMIT - 1)) begin
      rep_fail = 1'b1;
    end
  end

  // Harvest sequencer with registered outputs and health history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      word        <= '0;
      prev_word   <= '0;
      prev_valid  <= 1'b0;
      rep_cnt     <= '0;
      gen_freeze  <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      health_fail <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_RELEASE;
            gen_freeze <= 1'b0;
            cnt        <= '0;
          end
        end
        ST_RELEASE: begin
          if (cnt == CNT_W'(RELEASE_CYC - 1)) begin
            state      <= ST_SETTLE;
            gen_freeze <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state <= ST_CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          word  <= rnd_sync;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          prev_word  <= word;
          prev_valid <= 1'b1;
          rep_cnt    <= rep_next;
          if (rep_fail) begin
            state       <= ST_FAIL;
            health_fail <= 1'b1;
          end else begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_data  <= fold;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (enable) begin
              state      <= ST_RELEASE;
              gen_freeze <= 1'b0;
              cnt        <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_FAIL: begin
          if (fail_clr) begin
            state       <= ST_IDLE;
            health_fail <= 1'b0;
            rep_cnt     <= '0;
            prev_valid  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Debug view of the sequencer state and health history.
  always_comb begin
    dbg            = '0;
    dbg.state      = state;
    dbg.rep_cnt    = 8'(rep_cnt);
    dbg.prev_valid = prev_valid;
  end

endmodule

// File: tb/tb_rnd_harvest_ctrl.sv
// Directed bench for rnd_harvest_ctrl with default parameters.
module tb_rnd_harvest_ctrl;
  import snpu_rnd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] rnd_bits;
  logic        gen_freeze;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        health_fail;
  logic        fail_clr;
  dbg_t        dbg;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  rnd_harvest_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rnd_bits    (rnd_bits),
    .gen_freeze  (gen_freeze),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail),
    .fail_clr    (fail_clr),
    .dbg         (dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step at least once, then until out_valid or the bound expires.
  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < max_cyc);
    if (!out_valid) check("valid_timeout", out_valid, 1);
  endtask

  // Step until health_fail rises; records whether out_valid was seen meanwhile.
  task automatic wait_fail(input int max_cyc, output int n, output int saw_valid);
    n = 0;
    saw_valid = 0;
    do begin
      step();
      n++;
      if (out_valid) saw_valid = 1;
    end while (!health_fail && n < max_cyc);
    if (!health_fail) check("fail_timeout", health_fail, 1);
  endtask

  // Scoreboard: compare the presented byte with the oldest expected byte.
  task automatic check_byte(input string tag);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else check(tag, out_data, exp_q.pop_front());
  endtask

  logic [15:0] vec_bits[5];
  logic [7:0]  vec_byte[5];

  initial begin
    int n;
    int sv;
    int low_cnt;
    int bad;
    int max_rep;

    vec_bits[0] = 16'h1234; vec_byte[0] = 8'h26;
    vec_bits[1] = 16'h5678; vec_byte[1] = 8'h2E;
    vec_bits[2] = 16'h9ABC; vec_byte[2] = 8'h26;
    vec_bits[3] = 16'hA55A; vec_byte[3] = 8'hFF;
    vec_bits[4] = 16'h00C3; vec_byte[4] = 8'hC3;

    // Reset
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; fail_clr = 1'b0; rnd_bits = '0;
    repeat (3) step();
    check("rst_freeze", gen_freeze, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_fail", health_fail, 0);
    check("rst_state", dbg.state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) step();

    // Streaming with out_ready held high
    rnd_bits = vec_bits[0];
    exp_q.push_back(vec_byte[0]);
    out_ready = 1'b1;
    enable = 1'b1;
    low_cnt = 0;
    for (int e = 0; e <= 9; e++) begin
      step();
      if (e <= 8 && !gen_freeze) low_cnt++;
      if (e == 0) check("release_at_e0", gen_freeze, 0);
      if (e == 3) check("release_at_e3", gen_freeze, 0);
      if (e == 4) check("settle_at_e4", gen_freeze, 1);
      if (e == 8) check("no_valid_e8", out_valid, 0);
    end
    check("freeze_low_cycles", low_cnt, 4);
    check("valid_at_e9", out_valid, 1);
    check_byte("first_byte");

    for (int i = 1; i < 4; i++) begin
      rnd_bits = vec_bits[i];
      exp_q.push_back(vec_byte[i]);
      step();
      check("hs_valid_drop", out_valid, 0);
      check("hs_release", gen_freeze, 0);
      wait_valid(20, n);
      check("byte_gap", n, 9);
      check_byte("stream_byte");
    end

    // Backpressure on the A55A byte; input changes must not be captured
    out_ready = 1'b0;
    rnd_bits = vec_bits[4];
    exp_q.push_back(vec_byte[4]);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_data !== 8'hFF || gen_freeze !== 1'b1 || out_valid !== 1'b1 || dbg.state != ST_HOLD)
        bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_data", out_data, 8'hFF);
    out_ready = 1'b1;
    step();
    check("bp_hs_drop", out_valid, 0);
    check("bp_release_same_edge", gen_freeze, 0);
    wait_valid(20, n);
    check("bp_gap", n, 9);
    check_byte("bp_next_byte");

    // Drop enable; the handshake returns to IDLE
    enable = 1'b0;
    step();
    check("stop_state", dbg.state, ST_IDLE);
    check("stop_freeze", gen_freeze, 1);

    // Enable dropped during SETTLE: byte still delivered
    rnd_bits = 16'h3C00;
    exp_q.push_back(8'h3C);
    enable = 1'b1;
    repeat (6) step();
    check("mid_settle_state", dbg.state, ST_SETTLE);
    enable = 1'b0;
    wait_valid(20, n);
    check("settle_drop_gap", n, 4);
    check_byte("settle_drop_byte");
    step();
    check("settle_drop_idle", dbg.state, ST_IDLE);
    repeat (5) step();
    check("idle_stays_frozen", gen_freeze, 1);
    check("idle_no_valid", out_valid, 0);
    check("idle_stays", dbg.state, ST_IDLE);

    // Stuck-at-1 cells: three bytes, then health failure
    rnd_bits = 16'hFFFF;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      wait_valid(20, n);
      check_byte("stuck_byte");
    end
    wait_fail(20, n, sv);
    check("fail_gap", n, 10);
    check("fail_no_valid", sv, 0);
    check("fail_state", dbg.state, ST_FAIL);
    check("fail_freeze", gen_freeze, 1);
    repeat (3) step();
    check("fail_sticky", health_fail, 1);

    fail_clr = 1'b1;
    step();
    fail_clr = 1'b0;
    check("clr_fail", health_fail, 0);
    check("clr_state", dbg.state, ST_IDLE);
    check("clr_prev_valid", dbg.prev_valid, 0);
    check("clr_rep_cnt", dbg.rep_cnt, 0);
    step();
    check("clr_release_next", gen_freeze, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      wait_valid(20, n);
      check_byte("stuck_byte2");
    end
    wait_fail(20, n, sv);
    check("fail2_gap", n, 10);
    check("fail2_no_valid", sv, 0);
    enable = 1'b0;
    fail_clr = 1'b1;
    step();
    fail_clr = 1'b0;
    check("clr2_state", dbg.state, ST_IDLE);

    // Alternating patterns never trip the repetition test
    max_rep = 0;
    bad = 0;
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rnd_bits = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
      exp_q.push_back(8'h00);
      n = 0;
      do begin
        step();
        n++;
        if (int'(dbg.rep_cnt) > max_rep) max_rep = int'(dbg.rep_cnt);
        if (health_fail) bad++;
      end while (!out_valid && n < 30);
      if (!out_valid) check("alt_timeout", out_valid, 1);
      check_byte("alt_byte");
    end
    check("alt_max_rep", max_rep, 0);
    check("alt_no_fail", bad, 0);
    enable = 1'b0;
    step();
    check("alt_idle", dbg.state, ST_IDLE);

    // Asynchronous reset during RELEASE
    rnd_bits = 16'h1234;
    enable = 1'b1;
    repeat (2) step();
    check("pre_rst_release", gen_freeze, 0);
    rst_n = 1'b0;
    #1;
    check("arst_rel_freeze", gen_freeze, 1);
    check("arst_rel_state", dbg.state, ST_IDLE);
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    step();

    // Asynchronous reset during HOLD with repetition history built up
    rnd_bits = 16'h12FF;
    out_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hED);
      if (i == 2) begin
        n = 0;
        do begin
          step();
          n++;
          if (dbg.state == ST_CHECK) out_ready = 1'b0;
        end while (!out_valid && n < 20);
        if (!out_valid) check("hold_timeout", out_valid, 1);
      end else begin
        wait_valid(20, n);
      end
      check_byte("hist_byte");
    end
    check("pre_rst_rep", dbg.rep_cnt, 2);
    step();
    check("pre_rst_hold", dbg.state, ST_HOLD);
    rst_n = 1'b0;
    #1;
    check("arst_hold_valid", out_valid, 0);
    check("arst_hold_data", out_data, 0);
    check("arst_hold_freeze", gen_freeze, 1);
    check("arst_hold_fail", health_fail, 0);
    check("arst_hold_rep", dbg.rep_cnt, 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'hED);
    wait_valid(20, n);
    check_byte("post_rst_byte");
    check("post_rst_no_fail", health_fail, 0);
    check("post_rst_rep", dbg.rep_cnt, 0);
    enable = 1'b0;
    step();

    // Report
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rnd_harvest_ctrl.md
# rnd_harvest_ctrl

Sequencing controller for the bank of NAND-latch random cells (`funky_rnd`). It drives the shared generator line `G`: low to release the cells, high to freeze them. It lets the cells resolve, synchronises and captures the raw bits, and runs a repetition health test. It folds each capture to a byte and serves it to one consumer over a valid/ready handshake, between the latch bank and the top-level I/O.

## Interface

Parameters:
- `N_CELLS`, 16: number of latch cells; must be a multiple of 8.
- `RELEASE_CYC`, 4: cycles `gen_freeze` is held low per harvest; must be ≥1.
- `SETTLE_CYC`, 3: cycles after freeze before capture; must be ≥3, covering resolution plus the 2-flop sync.
- `REP_LIMIT`, 4: number of identical consecutive captures that declares failure; must be ≥2.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: start or continue harvesting; sampled only in IDLE and at handshake.
- `rnd_bits`, input, N_CELLS: raw, asynchronous latch outputs.
- `gen_freeze`, output, 1: drives every cell's G; 1 = freeze, 0 = random mode; registered.
- `out_data`, output, 8: folded random byte.
- `out_valid`, output, 1: `out_data` holds an unconsumed byte.
- `out_ready`, input, 1: consumer accepts the byte.
- `health_fail`, output, 1: sticky repetition-test failure.
- `fail_clr`, input, 1: clears FAIL and the health history.

## Operation

- States:
  - IDLE: `gen_freeze`=1; `enable`=1 → RELEASE.
  - RELEASE: `gen_freeze`=0 for RELEASE_CYC cycles → SETTLE.
  - SETTLE: `gen_freeze`=1 for SETTLE_CYC cycles → CAPTURE.
  - CAPTURE: the synchronised `rnd_bits` are loaded into `word` → CHECK.
  - CHECK: runs the health test, then goes to HOLD (`out_valid`=1) or FAIL.
  - HOLD: on handshake, → RELEASE if `enable`=1, otherwise → IDLE.
  - FAIL: `health_fail`=1 and `gen_freeze`=1; `fail_clr`=1 → IDLE.
- Synchronisation: all `rnd_bits` pass through a 2-flop synchroniser that runs continuously. Only the synchronised value is ever used.
- Fold: `out_data` = XOR of the N_CELLS/8 bytes of `word`. Byte 0 is bits [7:0].
- Health test:
  - `prev_valid` and `prev_word` hold the previous capture.
  - In CHECK, if `prev_valid` and `word`==`prev_word`, then `rep_cnt`+1; otherwise `rep_cnt`=0.
  - `prev_word` ← `word`; `prev_valid` ← 1.
  - If `rep_cnt` reaches REP_LIMIT−1 (REP_LIMIT identical captures), go to FAIL. The failing byte is not presented.
- `fail_clr` clears `rep_cnt` and `prev_valid`. It is ignored outside FAIL.
- `enable` dropping mid-harvest does not abort. The harvest completes and the byte is held until accepted.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a handshake.
- Reset (asynchronous, any state):
  - FSM → IDLE.
  - `gen_freeze`=1, `out_valid`=0, `out_data`=0, `health_fail`=0.
  - `rep_cnt`=0, `prev_valid`=0, sync flops 0.

## Timing

- Let edge 0 be the edge that samples `enable`=1 in IDLE.
- `gen_freeze`=0 from edge 0 to edge RELEASE_CYC (exactly RELEASE_CYC cycles low).
- CAPTURE occupies the cycle after edge RELEASE_CYC+SETTLE_CYC; `word` loads at edge RELEASE_CYC+SETTLE_CYC+1.
- `out_valid` rises at edge RELEASE_CYC+SETTLE_CYC+2 (edge 9 with defaults). FAIL and `health_fail` rise at that same edge instead, when the test fails.
- Handshake at edge T (`out_valid`·`out_ready`): `out_valid`=0 from T.
  - If `enable`=1, `gen_freeze`=0 from T as well.
  - The next `out_valid` rises at T+RELEASE_CYC+SETTLE_CYC+2.
  - Sustained throughput is one byte per 9 cycles with defaults.
- `fail_clr` sampled in FAIL at edge F: IDLE and `health_fail`=0 from F.
  - If `enable`=1 at edge F+1, RELEASE starts at F+1.

## Structure

- Shared package `snpu_rnd_pkg`:
  - FSM state encoding (7 states, 3 bits).
  - Default constants for N_CELLS, RELEASE_CYC, SETTLE_CYC and REP_LIMIT.
  - A byte-fold function.
- Sub-module `rnd_sync2`: a parameterised N-bit 2-flop synchroniser with async active-low reset.
- Everything else lives in one module: FSM, cycle counter sized for max(RELEASE_CYC, SETTLE_CYC), health registers, output register.
- Elaboration check: reject N_CELLS%8≠0, SETTLE_CYC<3, RELEASE_CYC<1, REP_LIMIT<2.

## Test plan

- Reset, then `enable`=1 and `out_ready`=1, with `rnd_bits` stepping 16'h1234, 16'h5678, … per harvest:
  - `gen_freeze` is low for exactly 4 cycles.
  - `out_valid` is first seen at edge 9 with `out_data`=8'h26.
  - Bytes then follow one per 9 cycles.
- Backpressure: `out_ready`=0 for 20 cycles after `out_valid`.
  - `out_data` is stable, `gen_freeze` stays 1, and no second capture occurs.
  - Raising `out_ready` gives one transfer, and RELEASE restarts at the same edge.
- `rnd_bits` held at 16'hFFFF:
  - Bytes 1–3 (8'h00) are delivered.
  - The 4th capture raises `health_fail` with no 4th `out_valid`.
  - `fail_clr` → IDLE and `health_fail`=0; three more bytes are delivered before failing again.
- Alternating 16'hAAAA and 16'h5555 for 50 harvests → never fails, `rep_cnt` stays 0.
- `enable` dropped during SETTLE → the byte is still delivered, then the FSM stays in IDLE with `gen_freeze`=1.
- `rst_n` asserted mid-RELEASE and mid-HOLD:
  - Outputs immediately (asynchronously) show the reset values: `gen_freeze`=1, `out_valid`=0, `out_data`=0, `health_fail`=0.
  - After reset, health history is empty: the first capture never counts as a repeat.
